timer_arbiter: RTL and testbench

- Round-robin scheduler that shares one down-counting interval timer among p_nreq requesters.
- Each requester asks for a delay of N cycles through a val/rdy handshake. The block grants the timer to one requester at a time, counts the interval, then pulses that requester's done bit.
- Used wherever several engines need cycle-accurate waits but the design carries only one wide timer.

---
 rtl/timer_arbiter.sv | 122 ++++++++++++
 tb/tb_timer_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin owner of one down-counting interval timer shared by p_nreq requesters.
// Latency: grant -> done pulse after N (+hold) RUN cycles; req_rdy only asserts in IDLE, so requesters wait while busy.
module timer_arbiter #(
   parameter int p_nreq  = 4,
   parameter int p_nbits = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [p_nreq-1:0]            req_val,
   input  logic [p_nreq*p_nbits-1:0]    req_cycles,
   output logic [p_nreq-1:0]            req_rdy,
   input  logic                         hold,
   input  logic                         abort,
   output logic [p_nreq-1:0]            done,
   output logic                         busy,
   output logic [$clog2(p_nreq)-1:0]    owner,
   output logic [p_nbits-1:0]           remain
);

   localparam int p_ow = $clog2(p_nreq);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [p_nbits-1:0] remain_nxt;
   logic [p_ow-1:0]    owner_nxt;
   logic [p_ow-1:0]    ptr, ptr_nxt;
   logic [p_ow-1:0]    sel;
   logic               sel_vld;
   logic               fire;
   logic [p_nbits-1:0] sel_cycles;

   // Walk downward so the candidate closest to ptr is the last one to win.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      for (int k = p_nreq - 1; k >= 0; k--) begin
         logic [p_ow-1:0] cand;
         cand = p_ow'((int'(ptr) + k) % p_nreq);
         if (req_val[cand]) begin
            sel     = cand;
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      req_rdy = '0;
      if (reset && state == IDLE && sel_vld)
         req_rdy[sel] = 1'b1;
   end

   assign fire       = |(req_val & req_rdy);
   assign sel_cycles = req_cycles[sel*p_nbits +: p_nbits];

   always_comb begin
      state_nxt  = state;
      remain_nxt = remain;
      owner_nxt  = owner;
      ptr_nxt    = ptr;
      case (state)
         IDLE: begin
            if (fire) begin
               state_nxt  = RUN;
               owner_nxt  = sel;
               ptr_nxt    = (sel == p_ow'(p_nreq - 1)) ? '0 : sel + 1'b1;
               remain_nxt = (sel_cycles == '0) ? p_nbits'(1) : sel_cycles;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt  = IDLE;
               remain_nxt = '0;
               owner_nxt  = '0;
            end else if (!hold) begin
               if (remain <= p_nbits'(1)) begin
                  state_nxt  = DONE;
                  remain_nxt = '0;
               end else begin
                  remain_nxt = remain - 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            owner_nxt = '0;
         end
         default: begin
            state_nxt  = IDLE;
            remain_nxt = '0;
            owner_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         remain <= '0;
         owner  <= '0;
         ptr    <= '0;
      end else begin
         state  <= state_nxt;
         remain <= remain_nxt;
         owner  <= owner_nxt;
         ptr    <= ptr_nxt;
      end
   end

   always_comb begin
      done = '0;
      if (reset && state == DONE)
         done[owner] = 1'b1;
   end

   assign busy = reset && (state != IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: expected grants/done owners queued at stimulus, checked at output.
module tb_timer_arbiter;

   localparam int NREQ = 4;
   localparam int NB   = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_val;
   logic [NREQ*NB-1:0] req_cycles;
   logic [NREQ-1:0]    req_rdy;
   logic               hold;
   logic               abort;
   logic [NREQ-1:0]    done;
   logic               busy;
   logic [1:0]         owner;
   logic [NB-1:0]      remain;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int exp_grant[$];
   int exp_done[$];
   int mon_e;

   timer_arbiter #(.p_nreq(NREQ), .p_nbits(NB)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_val    (req_val),
      .req_cycles (req_cycles),
      .req_rdy    (req_rdy),
      .hold       (hold),
      .abort      (abort),
      .done       (done),
      .busy       (busy),
      .owner      (owner),
      .remain     (remain)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cyc(input int i, input logic [NB-1:0] n);
      req_cycles[i*NB +: NB] = n;
   endtask

   // Scoreboard side: every handshake and every done pulse consumes one queued expectation.
   always @(negedge clk) begin
      if (reset && (req_val & req_rdy) != '0) begin
         if (exp_grant.size() > 0) begin
            mon_e = exp_grant.pop_front();
            chk("grant_idx", 64'(req_rdy), 64'(1) << mon_e);
         end else begin
            chk("grant_unexpected", 64'(req_rdy), 64'(0));
         end
      end
      if (done != '0) begin
         if (exp_done.size() > 0) begin
            mon_e = exp_done.pop_front();
            chk("done_owner", 64'(done), 64'(1) << mon_e);
         end else begin
            chk("done_unexpected", 64'(done), 64'(0));
         end
      end
   end

   initial begin
      int n;
      int prev;
      reset      = 1'b0;
      req_val    = '0;
      req_cycles = '0;
      hold       = 1'b0;
      abort      = 1'b0;

      // 1: reset state, then single N=5 interval
      req_val = 4'b0001;
      set_cyc(0, 5);
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_remain", remain, 0);
      chk("rst_owner", owner, 0);
      chk("rst_done", done, 0);
      chk("rst_rdy", req_rdy, 0);
      exp_grant.push_back(0);
      exp_done.push_back(0);
      reset = 1'b1;
      #1;
      chk("t1_rdy", req_rdy, 4'b0001);
      step();
      req_val = '0;
      for (int k = 5; k >= 1; k--) begin
         chk("t1_remain", remain, k);
         chk("t1_busy", busy, 1);
         step();
      end
      chk("t1_done", done, 4'b0001);
      step();
      chk("t1_idle", busy, 0);

      // 2: all four requesting, N=2 -> round robin 0,1,2,3,0 spaced 4 cycles
      reset = 1'b0;
      step();
      step();
      for (int i = 0; i < NREQ; i++) set_cyc(i, 2);
      req_val = 4'b1111;
      foreach (exp_grant[i]) ;
      exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
      exp_grant.push_back(3); exp_grant.push_back(0);
      exp_done.push_back(0); exp_done.push_back(1); exp_done.push_back(2);
      exp_done.push_back(3); exp_done.push_back(0);
      reset = 1'b1;
      #1;
      prev = 0;
      for (int g = 0; g < 5; g++) begin
         n = 0;
         while ((req_val & req_rdy) == '0 && n < 20) begin
            step();
            n++;
         end
         if (n >= 20) chk("t2_grant_timeout", n, 0);
         if (g > 0) chk("t2_gap", cyc - prev, 4);
         prev = cyc;
         step();
      end
      req_val = '0;
      step();
      step();
      step();
      chk("t2_idle", busy, 0);

      // 3: N=0 treated as one
      set_cyc(2, 0);
      req_val = 4'b0100;
      exp_grant.push_back(2);
      exp_done.push_back(2);
      #1;
      chk("t3_rdy", req_rdy, 4'b0100);
      step();
      req_val = '0;
      chk("t3_remain", remain, 1);
      step();
      chk("t3_done", done, 4'b0100);
      step();
      chk("t3_idle", busy, 0);

      // 4: N=10 with 3 hold cycles -> done 14 cycles after handshake
      set_cyc(1, 10);
      req_val = 4'b0010;
      exp_grant.push_back(1);
      exp_done.push_back(1);
      #1;
      chk("t4_rdy", req_rdy, 4'b0010);
      step();
      req_val = '0;
      chk("t4_remain_a", remain, 10);
      step();
      step();
      chk("t4_remain_b", remain, 8);
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t4_frozen", remain, 8);
      end
      hold = 1'b0;
      n = 6;
      while (done == '0 && n < 40) begin
         step();
         n++;
      end
      chk("t4_latency", n, 14);
      step();
      chk("t4_idle", busy, 0);

      // 5: abort (with hold) at 3rd RUN cycle, pending requester 0 granted straight away
      set_cyc(3, 8);
      set_cyc(0, 3);
      req_val = 4'b1001;
      exp_grant.push_back(3);
      exp_grant.push_back(0);
      exp_done.push_back(0);
      #1;
      chk("t5_rdy", req_rdy, 4'b1000);
      step();
      req_val = 4'b0001;
      step();
      step();
      chk("t5_remain", remain, 6);
      abort = 1'b1;
      hold  = 1'b1;
      step();
      abort = 1'b0;
      hold  = 1'b0;
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_remain", remain, 0);
      chk("t5_abort_done", done, 0);
      chk("t5_regrant", req_rdy, 4'b0001);
      step();
      req_val = '0;
      n = 0;
      while (done == '0 && n < 20) begin
         step();
         n++;
      end
      chk("t5_done", done, 4'b0001);
      step();
      chk("t5_idle", busy, 0);

      // 6: reset mid-RUN, ptr restart, and full-scale N
      set_cyc(1, 6);
      req_val = 4'b0010;
      exp_grant.push_back(1);
      #1;
      step();
      req_val = '0;
      step();
      step();
      chk("t6_remain", remain, 4);
      reset   = 1'b0;
      set_cyc(1, 32'hFFFF_FFFF);
      set_cyc(3, 5);
      req_val = 4'b1010;
      step();
      chk("t6_busy", busy, 0);
      chk("t6_remain0", remain, 0);
      chk("t6_owner", owner, 0);
      chk("t6_done", done, 0);
      chk("t6_rdy_in_rst", req_rdy, 0);
      exp_grant.push_back(1);
      reset = 1'b1;
      #1;
      chk("t6_rdy_ptr0", req_rdy, 4'b0010);
      step();
      req_val = '0;
      chk("t6_full", remain, 32'hFFFF_FFFF);
      step();
      chk("t6_full_dec", remain, 32'hFFFF_FFFE);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_idle", busy, 0);
      step();

      chk("grant_queue_empty", exp_grant.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
